// File: rtl/sdr_bank_cmd_gen_pkg.sv
// rtl/sdr_bank_cmd_gen_pkg.sv - shared types and constants for the SDRAM bank command generator
// Purpose: FSM state type, 4-bit pin command encodings {CSn,RASn,CASn,WEn}
//          and the READ/WRITE address-word builder.
// Ports:   none (package sdr_parameters).
package sdr_parameters;

  typedef enum logic [3:0] {
    IDLE,
    PRE,
    WAIT_RP,
    ACT,
    WAIT_RCD,
    RW,
    PREA,
    WAIT_RP_ALL,
    REF,
    WAIT_RFC
  } bank_fsm_t;

  localparam logic [3:0] CMD_INHIBIT      = 4'b1111;
  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
  localparam logic [3:0] CMD_READ         = 4'b0101;
  localparam logic [3:0] CMD_WRITE        = 4'b0100;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;

  // Column in the low col_w bits, auto-precharge flag on A10, all else zero.
  // col_w is at most 10, so the column never overlaps A10.
  function automatic logic [31:0] ap_addr(input logic [31:0] col,
                                          input int unsigned col_w,
                                          input logic        auto_pre);
    logic [31:0] a;
    a     = col & ((32'd1 << col_w) - 32'd1);
    a[10] = auto_pre;
    return a;
  endfunction

endpackage

// File: rtl/sdr_bank_tracker.sv
// rtl/sdr_bank_tracker.sv - per-bank open/row register file for the open-page policy
// Purpose: remembers which banks are open and the row each one holds.
// Ports:   clk_i, rst_i (sync, active high, closes all banks)
//          bank_i/row_i     lookup and action address
//          open_i           mark bank_i open with row_i
//          close_i          mark bank_i closed
//          close_all_i      mark every bank closed
//          hit_o/miss_o     bank_i open with matching / differing row
//          any_open_o       at least one bank open
module sdr_bank_tracker #(
  parameter int BANKS = 4,
  parameter int ROW_W = 13,
  localparam int BA_W = $clog2(BANKS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [BA_W-1:0]  bank_i,
  input  logic [ROW_W-1:0] row_i,
  input  logic             open_i,
  input  logic             close_i,
  input  logic             close_all_i,
  output logic             hit_o,
  output logic             miss_o,
  output logic             any_open_o
);

  logic [BANKS-1:0] open_q;
  logic [ROW_W-1:0] row_q [BANKS];

  always_ff @(posedge clk_i) begin
    if (rst_i || close_all_i) begin
      open_q <= '0;
    end else if (open_i) begin
      open_q[bank_i] <= 1'b1;
      row_q[bank_i]  <= row_i;
    end else if (close_i) begin
      open_q[bank_i] <= 1'b0;
    end
  end

  assign hit_o      = open_q[bank_i] && (row_q[bank_i] == row_i);
  assign miss_o     = open_q[bank_i] && (row_q[bank_i] != row_i);
  assign any_open_o = |open_q;

endmodule

// File: rtl/sdr_bank_cmd_gen.sv
// rtl/sdr_bank_cmd_gen.sv - multi-bank SDRAM pin command generator with refresh
// Purpose: turns an access request stream and refresh requests into registered
//          SDRAM commands, enforcing tRP/tRCD/tRFC. Open-page policy by default;
//          define SDR_AUTO_PRECHARGE_EN for closed-page (auto-precharge) operation.
// Ports:   pclk, preset (sync, active high), init_done (pins idle until set)
//          req_valid/req_ready, req_write, req_bank, req_row, req_col
//          ref_req (level), ref_ack (pulse in the cycle AUTO_REFRESH is issued)
//          sdr_CKE, sdr_CSn, sdr_RASn, sdr_CASn, sdr_WEn, sdr_BA, sdr_A (registered)
module sdr_bank_cmd_gen
  import sdr_parameters::*;
#(
  parameter int BANKS    = 4,
  parameter int ROW_W    = 13,
  parameter int COL_W    = 9,
  parameter int A_W      = 13,
  parameter int TRP_CYC  = 2,
  parameter int TRCD_CYC = 2,
  parameter int TRFC_CYC = 7,
  localparam int BA_W    = $clog2(BANKS)
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             init_done,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [BA_W-1:0]  req_bank,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  input  logic             ref_req,
  output logic             ref_ack,
  output logic             sdr_CKE,
  output logic             sdr_CSn,
  output logic             sdr_RASn,
  output logic             sdr_CASn,
  output logic             sdr_WEn,
  output logic [BA_W-1:0]  sdr_BA,
  output logic [A_W-1:0]   sdr_A
);

  localparam int T12   = (TRP_CYC > TRCD_CYC) ? TRP_CYC : TRCD_CYC;
  localparam int MAX_T = (T12 > TRFC_CYC) ? T12 : TRFC_CYC;
  localparam int CNT_W = $clog2(MAX_T + 1);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] RP_LD   = CNT_W'(TRP_CYC - 1);
  localparam logic [CNT_W-1:0] RCD_LD  = CNT_W'(TRCD_CYC - 1);
  localparam logic [CNT_W-1:0] RFC_LD  = CNT_W'(TRFC_CYC - 1);
  localparam logic [CNT_W-1:0] RP_FULL = CNT_W'(TRP_CYC);

`ifdef SDR_AUTO_PRECHARGE_EN
  // Closed page: WAIT_RP only follows RW and covers the auto-precharge tRP.
  localparam logic      AUTO_PRE = 1'b1;
  localparam bank_fsm_t RW_EXIT  = WAIT_RP;
  localparam bank_fsm_t RP_EXIT  = IDLE;
`else
  localparam logic      AUTO_PRE = 1'b0;
  localparam bank_fsm_t RW_EXIT  = IDLE;
  localparam bank_fsm_t RP_EXIT  = ACT;
`endif

  bank_fsm_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cmd_q, cmd_d;
  logic             cke_q, cke_d;
  logic [BA_W-1:0]  ba_q, ba_d;
  logic [A_W-1:0]   a_q, a_d;

  logic rst_all;
  logic hit, miss, any_open;
  logic trk_open, trk_close, trk_close_all;

  // Dropping init_done hands the pins back and forgets all open pages.
  assign rst_all = preset | ~init_done;

`ifdef SDR_AUTO_PRECHARGE_EN
  assign hit      = 1'b0;
  assign miss     = 1'b0;
  assign any_open = 1'b0;
`else
  sdr_bank_tracker #(
    .BANKS (BANKS),
    .ROW_W (ROW_W)
  ) u_tracker (
    .clk_i       (pclk),
    .rst_i       (rst_all),
    .bank_i      (req_bank),
    .row_i       (req_row),
    .open_i      (trk_open),
    .close_i     (trk_close),
    .close_all_i (trk_close_all),
    .hit_o       (hit),
    .miss_o      (miss),
    .any_open_o  (any_open)
  );
`endif

  // State and pin registers.
  always_ff @(posedge pclk) begin
    if (rst_all) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= CMD_INHIBIT;
      cke_q   <= 1'b0;
      ba_q    <= '1;
      a_q     <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      cke_q   <= cke_d;
      ba_q    <= ba_d;
      a_q     <= a_d;
    end
  end

  // Next state. Wait states are loaded with (param - 1) and skipped when that is 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ref_req) begin
          state_d = any_open ? PREA : REF;
        end else if (req_valid) begin
          if (hit)       state_d = RW;
          else if (miss) state_d = PRE;
          else           state_d = ACT;
        end
      end
      PRE: begin
        if (TRP_CYC > 1) begin state_d = WAIT_RP; cnt_d = RP_LD; end
        else state_d = ACT;
      end
      WAIT_RP: begin
        if (cnt_q <= ONE) state_d = RP_EXIT;
        else cnt_d = cnt_q - ONE;
      end
      ACT: begin
        if (TRCD_CYC > 1) begin state_d = WAIT_RCD; cnt_d = RCD_LD; end
        else state_d = RW;
      end
      WAIT_RCD: begin
        if (cnt_q <= ONE) state_d = RW;
        else cnt_d = cnt_q - ONE;
      end
      RW: begin
        state_d = RW_EXIT;
        cnt_d   = RP_FULL;
      end
      PREA: begin
        if (TRP_CYC > 1) begin state_d = WAIT_RP_ALL; cnt_d = RP_LD; end
        else state_d = REF;
      end
      WAIT_RP_ALL: begin
        if (cnt_q <= ONE) state_d = REF;
        else cnt_d = cnt_q - ONE;
      end
      REF: begin
        if (TRFC_CYC > 1) begin state_d = WAIT_RFC; cnt_d = RFC_LD; end
        else state_d = IDLE;
      end
      WAIT_RFC: begin
        if (cnt_q <= ONE) state_d = IDLE;
        else cnt_d = cnt_q - ONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: next pin values, handshakes and tracker updates.
  always_comb begin
    cmd_d         = CMD_NOP;
    cke_d         = 1'b1;
    ba_d          = '1;
    a_d           = '1;
    req_ready     = 1'b0;
    ref_ack       = 1'b0;
    trk_open      = 1'b0;
    trk_close     = 1'b0;
    trk_close_all = 1'b0;
    unique case (state_q)
      PRE: begin
        cmd_d     = CMD_PRECHARGE;
        ba_d      = req_bank;
        a_d       = '0;
        trk_close = 1'b1;
      end
      ACT: begin
        cmd_d    = CMD_ACTIVE;
        ba_d     = req_bank;
        a_d      = A_W'(req_row);
        trk_open = 1'b1;
      end
      RW: begin
        cmd_d     = req_write ? CMD_WRITE : CMD_READ;
        ba_d      = req_bank;
        a_d       = A_W'(ap_addr(32'(req_col), COL_W, AUTO_PRE));
        req_ready = 1'b1;
      end
      PREA: begin
        cmd_d         = CMD_PRECHARGE;
        ba_d          = '0;
        a_d           = '0;
        a_d[10]       = 1'b1;
        trk_close_all = 1'b1;
      end
      REF: begin
        cmd_d   = CMD_AUTO_REFRESH;
        ref_ack = 1'b1;
      end
      default: ;
    endcase
    // A reset or init drop in this cycle aborts the command: no handshake escapes.
    if (rst_all) begin
      req_ready = 1'b0;
      ref_ack   = 1'b0;
    end
  end

  assign sdr_CKE  = cke_q;
  assign sdr_CSn  = cmd_q[3];
  assign sdr_RASn = cmd_q[2];
  assign sdr_CASn = cmd_q[1];
  assign sdr_WEn  = cmd_q[0];
  assign sdr_BA   = ba_q;
  assign sdr_A    = a_q;

endmodule
